// File: rtl/eth_rx_frame_checker.sv
// RX frame checker: CRC-32/length/PHY checks on the MAC byte stream, FCS stripped
// through a 4-byte delay line, frame verdict on m_axis_tuser with tlast.
module eth_rx_frame_checker #(
    parameter int DATA_WIDTH    = 8,
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518,
    parameter int CNT_WIDTH     = 11
) (
    input  logic                  s_aclk,
    input  logic                  s_sresetn,
    input  logic [DATA_WIDTH-1:0] rx_axis_tdata,
    input  logic                  rx_axis_tvalid,
    input  logic                  rx_axis_tlast,
    input  logic                  rx_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_trdy,
    output logic                  stat_good,
    output logic                  stat_bad,
    output logic [3:0]            stat_err
);
    localparam logic [31:0]          CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0]          CRC_RES  = 32'hDEBB_20E3;
    localparam logic [CNT_WIDTH-1:0] MIN_C    = CNT_WIDTH'(MIN_FRAME_LEN);
    localparam logic [CNT_WIDTH-1:0] MAX_C    = CNT_WIDTH'(MAX_FRAME_LEN);

    typedef enum logic [2:0] {SYNC, IDLE, FILL, STREAM, ABORT} state_t;

    state_t                      state_q;
    logic [31:0]                 crc_q, crc_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
    logic                        phy_q, phy_d, ovf_q, drop_q, drop_d;
    logic [3:0][DATA_WIDTH-1:0]  dl_q;
    logic [DATA_WIDTH-1:0]       tdata_q;
    logic                        tvalid_q, tlast_q, tuser_q;
    logic                        good_q, bad_q;
    logic [3:0]                  err_q, err_d;
    logic                        out_free, crc_bad, len_bad;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    always_comb begin
        out_free = !tvalid_q || m_axis_trdy;
        crc_d    = crc_byte(crc_q, rx_axis_tdata);
        cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        phy_d    = phy_q | rx_axis_tuser;
        crc_bad  = crc_d != CRC_RES;
        len_bad  = (cnt_d < MIN_C) || (cnt_d > MAX_C);
        // a blocked final beat means the frame can only be closed by an abort beat
        err_d    = {ovf_q | !out_free, phy_d, len_bad, crc_bad};
        drop_d   = rx_axis_tvalid ? !rx_axis_tlast : drop_q;
    end

    always_ff @(posedge s_aclk or negedge s_sresetn) begin
        if (!s_sresetn) begin
            state_q  <= SYNC;
            crc_q    <= CRC_INIT;
            cnt_q    <= '0;
            phy_q    <= 1'b0;
            ovf_q    <= 1'b0;
            drop_q   <= 1'b0;
            dl_q     <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
            good_q   <= 1'b0;
            bad_q    <= 1'b0;
            err_q    <= '0;
        end else begin
            good_q <= 1'b0;
            bad_q  <= 1'b0;
            err_q  <= '0;
            if (out_free) tvalid_q <= 1'b0;

            if (rx_axis_tvalid && (state_q == IDLE || state_q == FILL || state_q == STREAM)) begin
                dl_q  <= {dl_q[2:0], rx_axis_tdata};
                crc_q <= crc_d;
                cnt_q <= cnt_d;
                phy_q <= phy_d;
                if (rx_axis_tlast) begin
                    crc_q <= CRC_INIT;
                    cnt_q <= '0;
                    phy_q <= 1'b0;
                    ovf_q <= 1'b0;
                end
            end

            case (state_q)
                SYNC: if (rx_axis_tvalid && rx_axis_tlast) begin
                    state_q <= IDLE;
                    if (drop_q) begin
                        bad_q  <= 1'b1;
                        err_q  <= 4'b1000;
                        drop_q <= 1'b0;
                    end
                end
                IDLE, FILL: if (rx_axis_tvalid) begin
                    // frames of 4 bytes or fewer never produce an output beat
                    if (rx_axis_tlast) begin
                        state_q <= IDLE;
                        bad_q   <= 1'b1;
                        err_q   <= {1'b0, phy_d, 1'b1, crc_bad};
                    end else if (state_q == IDLE) begin
                        state_q <= FILL;
                    end else if (cnt_q == CNT_WIDTH'(3)) begin
                        state_q <= STREAM;
                    end
                end
                STREAM: if (rx_axis_tvalid) begin
                    if (out_free) begin
                        tdata_q  <= dl_q[3];
                        tvalid_q <= 1'b1;
                        tlast_q  <= rx_axis_tlast;
                        tuser_q  <= rx_axis_tlast && (ovf_q | phy_d | len_bad | crc_bad);
                    end else if (!rx_axis_tlast) begin
                        ovf_q <= 1'b1;
                    end
                    if (rx_axis_tlast) begin
                        state_q <= out_free ? IDLE : ABORT;
                        good_q  <= (err_d == 4'b0000);
                        bad_q   <= (err_d != 4'b0000);
                        err_q   <= err_d;
                    end
                end
                ABORT: begin
                    drop_q <= drop_d;
                    if (rx_axis_tvalid && rx_axis_tlast) begin
                        bad_q <= 1'b1;
                        err_q <= 4'b1000;
                    end
                    if (out_free) begin
                        tdata_q  <= '0;
                        tvalid_q <= 1'b1;
                        tlast_q  <= 1'b1;
                        tuser_q  <= 1'b1;
                        state_q  <= drop_d ? SYNC : IDLE;
                    end
                end
                default: state_q <= SYNC;
            endcase
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign stat_good     = good_q;
    assign stat_bad      = bad_q;
    assign stat_err      = err_q;
endmodule
